mem_bus_arbiter: RTL and testbench

Shares the single data-memory/IO bus between two requesters: the CPU (LOAD/STORE/IN/OUT sequencing from the control unit) and an external IO/DMA master. It accepts req/ack transactions, arbitrates round-robin or with fixed CPU priority, and drives one memory access at a time. The memory may insert wait states through mem_ready. A timeout converts a hung access into an error completion.

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and defaults for the memory bus arbiter
// Contents: FSM state encoding, requester ids, default timeout length.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_IO  = 1'b1
  } req_id_t;

  localparam int DEFAULT_WAIT_MAX = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin / fixed-priority winner select (combinational)
// Ports:
//   cpu_req, io_req : request levels
//   last_grant      : requester that completed the previous transaction
//   winner          : selected requester (only meaningful when any_req)
//   any_req         : at least one request is pending
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic    cpu_req,
  input  logic    io_req,
  input  req_id_t last_grant,
  output req_id_t winner,
  output logic    any_req
);

  always_comb begin
    any_req = cpu_req | io_req;
    winner  = REQ_CPU;
    if (cpu_req && io_req) begin
      // On a tie, round-robin hands the bus to whoever did not have it last.
      if (FIXED_PRIO != 0) winner = REQ_CPU;
      else                 winner = (last_grant == REQ_CPU) ? REQ_IO : REQ_CPU;
    end else if (io_req) begin
      winner = REQ_IO;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory/IO bus between the CPU and an IO/DMA master
// Ports:
//   clk, reset                       : clock, async active-high reset
//   cpu_req/we/addr/wdata, cpu_gnt/ack : CPU requester side
//   io_req/we/addr/wdata,  io_gnt/ack  : IO/DMA requester side
//   rdata, err                       : completion data and timeout flag, valid with ack
//   busy                             : a transaction is in flight
//   mem_en/we/addr/wdata, mem_rdata, mem_ready : memory bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int WAIT_MAX   = DEFAULT_WAIT_MAX,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  // Counter value seen during the last ACCESS cycle allowed before timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state;
  req_id_t          owner;
  req_id_t          last_grant;
  req_id_t          winner;
  logic             any_req;
  logic [CNT_W-1:0] wait_cnt;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rr_arbiter2 (
    .cpu_req   (cpu_req),
    .io_req    (io_req),
    .last_grant(last_grant),
    .winner    (winner),
    .any_req   (any_req)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= REQ_IO;
      last_grant <= REQ_IO;
      wait_cnt   <= '0;
      cpu_gnt    <= 1'b0;
      io_gnt     <= 1'b0;
      cpu_ack    <= 1'b0;
      io_ack     <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            // mem_addr/mem_wdata double as the latched request; later
            // requester changes cannot disturb the access in flight.
            owner     <= winner;
            cpu_gnt   <= (winner == REQ_CPU);
            io_gnt    <= (winner == REQ_IO);
            mem_en    <= 1'b1;
            mem_we    <= (winner == REQ_CPU) ? cpu_we    : io_we;
            mem_addr  <= (winner == REQ_CPU) ? cpu_addr  : io_addr;
            mem_wdata <= (winner == REQ_CPU) ? cpu_wdata : io_wdata;
            wait_cnt  <= '0;
            state     <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          // mem_ready takes precedence over an expiring counter.
          if (mem_ready || wait_cnt == CNT_LAST) begin
            rdata   <= mem_ready ? mem_rdata : '0;
            err     <= ~mem_ready;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= (owner == REQ_CPU);
            io_ack  <= (owner == REQ_IO);
            state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          cpu_ack    <= 1'b0;
          io_ack     <= 1'b0;
          cpu_gnt    <= 1'b0;
          io_gnt     <= 1'b0;
          last_grant <= owner;
          wait_cnt   <= '0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req, cpu_we, io_req, io_we, mem_ready;
  logic [7:0] cpu_addr, cpu_wdata, io_addr, io_wdata, mem_rdata;

  logic       cpu_gnt, cpu_ack, io_gnt, io_ack, err, busy, mem_en, mem_we;
  logic [7:0] rdata, mem_addr, mem_wdata;

  logic       fp_cpu_gnt, fp_cpu_ack, fp_io_gnt, fp_io_ack, fp_err, fp_busy, fp_mem_en, fp_mem_we;
  logic [7:0] fp_rdata, fp_mem_addr, fp_mem_wdata;

  typedef struct packed {
    logic       io;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_MAX(15), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_ack(io_ack),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_MAX(15), .FIXED_PRIO(1)) u_dut_fp (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(fp_cpu_gnt), .cpu_ack(fp_cpu_ack),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(fp_io_gnt), .io_ack(fp_io_ack),
    .rdata(fp_rdata), .err(fp_err), .busy(fp_busy),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ack(input logic io, input logic [7:0] rd, input logic e);
    exp_t x;
    x.io    = io;
    x.rdata = rd;
    x.err   = e;
    sb_q.push_back(x);
  endtask

  // Completion monitor: every ack must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      check("gnt_mutex", 32'(cpu_gnt & io_gnt), 0);
      if (cpu_ack || io_ack) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_ack", 32'({cpu_ack, io_ack}), 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_ack_owner", 32'({cpu_ack, io_ack}), e.io ? 'b01 : 'b10);
          check("sb_ack_gnt", 32'(e.io ? io_gnt : cpu_gnt), 1);
          check("sb_rdata", 32'(rdata), 32'(e.rdata));
          check("sb_err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, limit %0d", $time, 100000);
    $fatal(1);
  end

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req = 0; io_we = 0; io_addr = 0; io_wdata = 0;
    mem_ready = 1; mem_rdata = 0;

    // Reset state
    repeat (2) tick();
    check("rst_ctrl", 32'({cpu_gnt, cpu_ack, io_gnt, io_ack, err, busy, mem_en, mem_we}), 0);
    check("rst_bus", 32'({mem_addr, mem_wdata, rdata}), 0);
    reset = 0;

    // Both requesting continuously: RR alternates from CPU, fixed prio keeps CPU
    cpu_req = 1; io_req = 1; cpu_addr = 'h20; io_addr = 'h30; mem_rdata = 'h11;
    for (int k = 0; k < 4; k++) expect_ack(k[0], 8'h11, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_cpu_gnt", 32'(cpu_gnt), (k % 2 == 0) ? 1 : 0);
      check("rr_io_gnt", 32'(io_gnt), (k % 2 == 0) ? 0 : 1);
      check("rr_addr", 32'(mem_addr), (k % 2 == 0) ? 'h20 : 'h30);
      check("fp_cpu_gnt", 32'({fp_cpu_gnt, fp_io_gnt}), 'b10);
      tick();
      tick();
    end
    cpu_req = 0; io_req = 0;
    tick();

    // CPU read, zero wait states
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h10; mem_rdata = 'hA5;
    expect_ack(1'b0, 8'hA5, 1'b0);
    tick();
    check("rd_en", 32'(mem_en), 1);
    check("rd_addr", 32'(mem_addr), 'h10);
    check("rd_we", 32'(mem_we), 0);
    check("rd_gnt", 32'({cpu_gnt, io_gnt}), 'b10);
    cpu_req = 0;
    tick();
    check("rd_ack", 32'(cpu_ack), 1);
    check("rd_en_1cyc", 32'(mem_en), 0);
    check("rd_rdata", 32'(rdata), 'hA5);
    check("rd_io_gnt", 32'(io_gnt), 0);
    tick();
    check("rd_idle", 32'({busy, cpu_ack, cpu_gnt}), 0);

    // IO write with 3 wait states; requester inputs scrambled after grant
    io_req = 1; io_we = 1; io_addr = 'h3F; io_wdata = 'h5C; mem_ready = 0; mem_rdata = 'h77;
    expect_ack(1'b1, 8'h77, 1'b0);
    tick();
    io_req = 0; io_addr = 'h00; io_wdata = 'h00;
    for (int i = 0; i < 4; i++) begin
      check("wr_en", 32'(mem_en), 1);
      check("wr_we", 32'(mem_we), 1);
      check("wr_addr", 32'(mem_addr), 'h3F);
      check("wr_wdata", 32'(mem_wdata), 'h5C);
      check("wr_no_ack", 32'(io_ack), 0);
      if (i == 3) mem_ready = 1;
      tick();
    end
    check("wr_ack", 32'(io_ack), 1);
    check("wr_en_off", 32'(mem_en), 0);
    check("wr_gnt_done", 32'(io_gnt), 1);
    tick();
    check("wr_gnt_off", 32'(io_gnt), 0);
    io_we = 0;

    // Timeout: mem_ready never comes
    mem_ready = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 'h44; mem_rdata = 'hFF;
    expect_ack(1'b0, 8'h00, 1'b1);
    tick();
    cpu_req = 0;
    for (int i = 1; i <= 15; i++) begin
      check("to_en", 32'(mem_en), 1);
      check("to_no_ack", 32'(cpu_ack), 0);
      tick();
    end
    check("to_ack", 32'(cpu_ack), 1);
    check("to_err", 32'(err), 1);
    check("to_rdata", 32'(rdata), 0);
    check("to_en_off", 32'(mem_en), 0);
    tick();
    check("to_err_hold", 32'(err), 1);
    mem_ready = 1; cpu_req = 1; cpu_addr = 'h45; mem_rdata = 'h3C;
    expect_ack(1'b0, 8'h3C, 1'b0);
    tick();
    cpu_req = 0;
    tick();
    check("after_to_ack", 32'(cpu_ack), 1);
    check("after_to_err", 32'(err), 0);
    tick();

    // Requester changes mid-ACCESS are ignored
    mem_ready = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 'h55; cpu_wdata = 'h66; mem_rdata = 'h99;
    expect_ack(1'b0, 8'h99, 1'b0);
    tick();
    cpu_req = 0; cpu_addr = 'hAA; cpu_wdata = 'hBB;
    tick();
    check("chg_addr", 32'(mem_addr), 'h55);
    check("chg_wdata", 32'(mem_wdata), 'h66);
    mem_ready = 1;
    tick();
    check("chg_ack", 32'(cpu_ack), 1);
    tick();
    check("chg_ack_once", 32'(cpu_ack), 0);
    cpu_we = 0;

    // Reset during ACCESS: immediate clear, no ack, CPU wins the next tie
    mem_ready = 0; io_req = 1; io_addr = 'h12;
    tick();
    check("rm_gnt", 32'(io_gnt), 1);
    io_req = 0;
    reset = 1;
    #1;
    check("rm_ctrl", 32'({cpu_gnt, cpu_ack, io_gnt, io_ack, err, busy, mem_en, mem_we}), 0);
    check("rm_bus", 32'({mem_addr, mem_wdata, rdata}), 0);
    tick();
    reset = 0;
    cpu_req = 1; io_req = 1; mem_ready = 1; mem_rdata = 'hE1; cpu_addr = 'h21; io_addr = 'h31;
    expect_ack(1'b0, 8'hE1, 1'b0);
    tick();
    check("post_rst_gnt", 32'({cpu_gnt, io_gnt}), 'b10);
    cpu_req = 0; io_req = 0;
    tick();
    tick();
    tick();

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
